uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit AXI-Stream slave (16-bit word stream) among NUM_CH independent AXI-Stream sources.
- Uses packet-level round-robin arbitration: a grant is held until the source's tlast, or until a MAX_BURST word limit forces release.
- When ID_PREFIX=1, inserts one header word carrying the channel index ahead of each granted burst, so the far end can demultiplex.
- Sits between the requesters and the UART top-level s_axis_* inputs.

Parameters:
- NUM_CH, 4, number of requesting sources; legal range 2..16.
- DATA_WIDTH, 16, word width on every stream; matches the UART data path.
- ID_PREFIX, 1, 1 = emit a header word before each burst; 0 = no header.
- HDR_TAG, 8'hF0, upper tag of the header word; header = {HDR_TAG, 4'b0, ch[3:0]} zero-extended or truncated to DATA_WIDTH.
- MAX_BURST, 64, maximum data words per grant; 0 = unlimited (release only on tlast).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  per-channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- s_axis_tready  out  NUM_CH  per-channel ready; one-hot or zero.
- m_axis_tdata  out  DATA_WIDTH  to the UART s_axis_tdata.
- m_axis_tvalid  out  1  to the UART s_axis_tvalid.
- m_axis_tready  in  1  from the UART s_axis_tready.
- grant_id  out  4  index of the current or last granted channel.
- busy  out  1  high in HDR or DATA.

Behaviour:
- Reset (asynchronous, aresetn=0) forces:
  - state = IDLE
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0
  - grant_id = 0, busy = 0, burst counter = 0
  - round-robin pointer = NUM_CH-1, so channel 0 has first priority.
- Reset mid-burst abandons the burst; no partial header or data is replayed after reset.
- States: IDLE, HDR, DATA.
- IDLE:
  - Each cycle, scan s_axis_tvalid starting at pointer+1 with wrap-around modulo NUM_CH; the first asserted channel wins.
  - On a win, register grant_id = winner and pointer = winner.
  - Next state is HDR if ID_PREFIX=1, else DATA.
  - Arbitration latency: 1 cycle from tvalid sampled to the first m_axis_tvalid.
  - No output valid and all s_axis_tready = 0 in IDLE.
- HDR:
  - m_axis_tvalid = 1 (registered) and m_axis_tdata = header word.
  - All s_axis_tready = 0.
  - On m_axis_tready = 1, go to DATA.
  - Hold the header stable while m_axis_tready = 0.
- DATA:
  - Combinational pass-through from the granted channel g:
    - m_axis_tdata = s_axis_tdata[g]
    - m_axis_tvalid = s_axis_tvalid[g]
    - s_axis_tready[g] = m_axis_tready
    - all other tready = 0.
  - A beat completes when s_axis_tvalid[g] and m_axis_tready are both high.
  - On each beat, the burst counter increments; width is clog2(MAX_BURST+1).
  - Release to IDLE on a beat with s_axis_tlast[g] = 1, or when MAX_BURST != 0 and the counter equals MAX_BURST-1.
  - On release, the counter clears.
  - A forced release does not wait for tlast; the remainder of that packet competes again and gets a fresh header.
- Idle cycle and fairness:
  - One IDLE cycle always separates bursts.
  - Back-to-back requests from all channels are served 0,1,2,…,NUM_CH-1,0.
  - A lone requester is re-granted after its one IDLE cycle.
- Simultaneous tlast and counter limit: a single release.
- Source deasserting tvalid mid-burst: the grant is held and the arbiter waits; there is no timeout.
- AXI rule: the header, once valid, is never withdrawn before its handshake.
- busy = (state != IDLE); grant_id holds its value through IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum {IDLE, HDR, DATA}
  - a HDR_TAG default constant
  - the function hdr_word(ch).
- One sub-module, rr_arbiter: NUM_CH request vector + pointer in, one-hot grant + index out, purely combinational rotate-priority. It is reusable for the receive-side demultiplexer.
- The FSM and counter stay in the top level.

Test Plan:
- Single packet: reset, then ch2 sends 3 words 0x0011, 0x0022, 0x0033 with tlast on the third, m_axis_tready=1. Required m-stream: 0xF002, 0x0011, 0x0022, 0x0033; busy high for 4 cycles; grant_id=2.
- Round-robin: after reset, ch0 and ch3 valid simultaneously, 1-word packets each. Required order: ch0 header 0xF000 and word, then 0xF003 and word. Next simultaneous ch0/ch3 request gives ch0 again, because the pointer is at 3 and 3+1 wraps to 0.
- Backpressure: m_axis_tready toggles 1/0 every cycle during a ch1 5-word packet. Required: each word appears exactly once, tdata stable while tvalid=1 and tready=0, s_axis_tready[1] mirrors m_axis_tready, other tready stay 0.
- Burst limit: MAX_BURST=4, ch0 streams 6 words, tlast on the 6th, ch1 idle. Required: 0xF000 + 4 words, 1 IDLE cycle, 0xF000 + 2 words.
- Reset mid-operation: aresetn driven low during DATA of ch1 word 2. Required on the same edge: m_axis_tvalid=0, all s_axis_tready=0, busy=0, grant_id=0. After release, the first grant goes to the lowest-index requester.
- ID_PREFIX=0: ch3 sends 2 words. Required: exactly 2 output beats, first output valid 1 cycle after the request.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, default header tag and header-word builder shared by the UART stream blocks
package uart_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  localparam logic [7:0] HDR_TAG_DEF = 8'hF0;
  function automatic logic [15:0] hdr_word(input logic [3:0] ch, input logic [7:0] tag = HDR_TAG_DEF);
    return {tag, 4'b0, ch};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority arbiter, search starts one past ptr and wraps
//   req   in  N   request vector
//   ptr   in  IW  last winner; it has lowest priority this round
//   gnt   out N   one-hot grant, zero when no request
//   idx   out IW  index of the winner
//   valid out 1   some request is present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] c;
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = '0;
    for (int i = 1; i <= N; i++) begin
      c = IW'((int'(ptr) + i) % N);
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin mux of NUM_CH AXI-Stream sources onto the UART TX stream
//   aclk/aresetn      clock, asynchronous active-low reset
//   s_axis_*          per-channel slave streams, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*          merged stream towards the UART
//   grant_id          current or last granted channel
//   busy              a burst (header or data) is in progress
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int             NUM_CH     = 4,
  parameter int             DATA_WIDTH = 16,
  parameter int             ID_PREFIX  = 1,
  parameter logic [7:0]     HDR_TAG    = HDR_TAG_DEF,
  parameter int             MAX_BURST  = 64
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [3:0]                   grant_id,
  output logic                         busy
);
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1;
  state_t state, state_n;
  logic [IW-1:0] ptr, gsel, arb_idx;
  logic [NUM_CH-1:0] arb_gnt, gnt_q;
  logic arb_valid, beat, rel;
  logic [CW-1:0] cnt;
  rr_arbiter #(.N(NUM_CH), .IW(IW)) u_rr (
    .req(s_axis_tvalid),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .valid(arb_valid)
  );
  assign grant_id = 4'(gsel);
  assign busy = state != IDLE;
  assign beat = state == DATA && s_axis_tvalid[gsel] && m_axis_tready;
  // a beat that is both tlast and the burst limit releases once, as either alone would
  assign rel = beat && (s_axis_tlast[gsel] || (MAX_BURST != 0 && cnt == CW'(MAX_BURST - 1)));
  always_comb begin
    state_n = state == IDLE ? (arb_valid ? (ID_PREFIX != 0 ? HDR : DATA) : IDLE) :
              state == HDR  ? (m_axis_tready ? DATA : HDR) :
              (rel ? IDLE : DATA);
    m_axis_tvalid = state == HDR || (state == DATA && s_axis_tvalid[gsel]);
    m_axis_tdata  = state == HDR  ? DATA_WIDTH'(hdr_word(4'(gsel), HDR_TAG)) :
                    state == DATA ? s_axis_tdata[gsel*DATA_WIDTH +: DATA_WIDTH] : '0;
    s_axis_tready = (state == DATA && m_axis_tready) ? gnt_q : '0;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      ptr   <= IW'(NUM_CH - 1);
      gsel  <= '0;
      gnt_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && arb_valid) begin
        ptr   <= arb_idx;
        gsel  <= arb_idx;
        gnt_q <= arb_gnt;
      end
      cnt <= rel ? '0 : beat ? cnt + CW'(1) : cnt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the arbiter in default, MAX_BURST=4 and ID_PREFIX=0 builds
module tb_uart_tx_arbiter;
  logic aclk = 1'b0, aresetn = 1'b0, m_ready = 1'b1;
  logic [63:0] tdata = '0;
  logic [3:0] tvalid = '0, tlast = '0;
  logic [3:0] sr [3];
  logic [15:0] md [3];
  logic mv [3];
  logic [3:0] gid [3];
  logic bsy [3];
  int total = 0, fails = 0, k, ph;
  logic done, bv, bh;
  logic [15:0] bd [11] = '{16'h0, 16'hF000, 16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04,
                           16'h0, 16'hF000, 16'h0C05, 16'h0C06, 16'h0};
  always #5 aclk = ~aclk;
  uart_tx_arbiter dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(sr[0]), .m_axis_tdata(md[0]), .m_axis_tvalid(mv[0]),
    .m_axis_tready(m_ready), .grant_id(gid[0]), .busy(bsy[0]));
  uart_tx_arbiter #(.MAX_BURST(4)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(sr[1]), .m_axis_tdata(md[1]), .m_axis_tvalid(mv[1]),
    .m_axis_tready(m_ready), .grant_id(gid[1]), .busy(bsy[1]));
  uart_tx_arbiter #(.ID_PREFIX(0)) dut_n (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast), .s_axis_tready(sr[2]), .m_axis_tdata(md[2]), .m_axis_tvalid(mv[2]),
    .m_axis_tready(m_ready), .grant_id(gid[2]), .busy(bsy[2]));
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic ck(string tag, int s, logic v, logic [15:0] d, logic [3:0] r, logic b);
    chk({tag, ".valid"}, 16'(mv[s]), 16'(v));
    if (v) chk({tag, ".data"}, md[s], d);
    chk({tag, ".tready"}, 16'(sr[s]), 16'(r));
    chk({tag, ".busy"}, 16'(bsy[s]), 16'(b));
  endtask
  task automatic put(int ch, logic [15:0] d, logic v, logic l);
    tdata[ch*16 +: 16] = d;
    tvalid[ch] = v;
    tlast[ch] = l;
  endtask
  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask
  task automatic mid();
    @(negedge aclk);
  endtask
  task automatic rst();
    aresetn = 1'b0;
    tvalid = '0;
    tlast = '0;
    tdata = '0;
    m_ready = 1'b1;
    nxt();
    aresetn = 1'b1;
  endtask
  initial begin
    nxt();
    mid();
    ck("rst", 0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("rst.tdata", md[0], 16'h0);
    chk("rst.gid", 16'(gid[0]), 16'h0);
    nxt();
    aresetn = 1'b1;
    put(2, 16'h0011, 1'b1, 1'b0);
    mid(); ck("p1.idle", 0, 1'b0, 16'h0, 4'h0, 1'b0); nxt();
    mid(); ck("p1.hdr", 0, 1'b1, 16'hF002, 4'h0, 1'b1); chk("p1.gid", 16'(gid[0]), 16'd2); nxt();
    mid(); ck("p1.w0", 0, 1'b1, 16'h0011, 4'b0100, 1'b1); nxt();
    put(2, 16'h0022, 1'b1, 1'b0);
    mid(); ck("p1.w1", 0, 1'b1, 16'h0022, 4'b0100, 1'b1); nxt();
    put(2, 16'h0033, 1'b1, 1'b1);
    mid(); ck("p1.w2", 0, 1'b1, 16'h0033, 4'b0100, 1'b1); nxt();
    put(2, 16'h0, 1'b0, 1'b0);
    mid(); ck("p1.end", 0, 1'b0, 16'h0, 4'h0, 1'b0); chk("p1.gidhold", 16'(gid[0]), 16'd2);
    rst();
    put(0, 16'h00A0, 1'b1, 1'b1);
    put(3, 16'h00A3, 1'b1, 1'b1);
    mid(); ck("rr.idle0", 0, 1'b0, 16'h0, 4'h0, 1'b0); nxt();
    mid(); ck("rr.hdr0", 0, 1'b1, 16'hF000, 4'h0, 1'b1); nxt();
    mid(); ck("rr.w0", 0, 1'b1, 16'h00A0, 4'b0001, 1'b1); nxt();
    put(0, 16'h0, 1'b0, 1'b0);
    mid(); ck("rr.idle1", 0, 1'b0, 16'h0, 4'h0, 1'b0); nxt();
    mid(); ck("rr.hdr3", 0, 1'b1, 16'hF003, 4'h0, 1'b1); chk("rr.gid3", 16'(gid[0]), 16'd3); nxt();
    mid(); ck("rr.w3", 0, 1'b1, 16'h00A3, 4'b1000, 1'b1); nxt();
    put(0, 16'h00B0, 1'b1, 1'b1);
    put(3, 16'h00B3, 1'b1, 1'b1);
    mid(); ck("rr.idle2", 0, 1'b0, 16'h0, 4'h0, 1'b0); nxt();
    mid(); ck("rr.wrap", 0, 1'b1, 16'hF000, 4'h0, 1'b1); chk("rr.gidwrap", 16'(gid[0]), 16'd0);
    rst();
    k = 0; ph = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      m_ready = (c % 2) == 1;
      put(1, 16'h0101 + 16'(k), k < 5, k == 4);
      mid();
      ck($sformatf("bp%0d", c), 0, ph == 1 || (ph == 2 && k < 5),
         ph == 1 ? 16'hF001 : 16'h0101 + 16'(k), (ph == 2 && m_ready) ? 4'b0010 : 4'b0000, ph != 0);
      nxt();
      if (ph == 0) ph = 1;
      else if (ph == 1 && m_ready) ph = 2;
      else if (ph == 2 && m_ready) begin
        k++;
        if (k == 5) begin ph = 0; done = 1'b1; end
      end
    end
    chk("bp.words", 16'(k), 16'd5);
    put(1, 16'h0, 1'b0, 1'b0);
    mid(); ck("bp.end", 0, 1'b0, 16'h0, 4'h0, 1'b0);
    rst();
    k = 0;
    for (int c = 0; c < 11; c++) begin
      put(0, 16'h0C01 + 16'(k), k < 6, k == 5);
      mid();
      bv = bd[c] != 16'h0;
      bh = bd[c] == 16'hF000;
      ck($sformatf("burst%0d", c), 1, bv, bd[c], (bv && !bh) ? 4'b0001 : 4'b0000, bv);
      nxt();
      if (bv && !bh) k++;
    end
    rst();
    put(1, 16'h0201, 1'b1, 1'b0);
    mid(); nxt();
    mid(); ck("mr.hdr", 0, 1'b1, 16'hF001, 4'h0, 1'b1); nxt();
    mid(); ck("mr.w1", 0, 1'b1, 16'h0201, 4'b0010, 1'b1); nxt();
    put(1, 16'h0202, 1'b1, 1'b0);
    mid(); ck("mr.w2", 0, 1'b1, 16'h0202, 4'b0010, 1'b1);
    aresetn = 1'b0;
    #1;
    ck("mr.rst", 0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("mr.gid", 16'(gid[0]), 16'd0);
    put(3, 16'h0303, 1'b1, 1'b1);
    nxt();
    aresetn = 1'b1;
    mid(); ck("mr.idle", 0, 1'b0, 16'h0, 4'h0, 1'b0); nxt();
    mid(); ck("mr.regrant", 0, 1'b1, 16'hF001, 4'h0, 1'b1); chk("mr.gid1", 16'(gid[0]), 16'd1);
    rst();
    put(3, 16'h0301, 1'b1, 1'b0);
    mid(); ck("np.idle", 2, 1'b0, 16'h0, 4'h0, 1'b0); nxt();
    mid(); ck("np.w0", 2, 1'b1, 16'h0301, 4'b1000, 1'b1); chk("np.gid", 16'(gid[2]), 16'd3); nxt();
    put(3, 16'h0302, 1'b1, 1'b1);
    mid(); ck("np.w1", 2, 1'b1, 16'h0302, 4'b1000, 1'b1); nxt();
    put(3, 16'h0, 1'b0, 1'b0);
    mid(); ck("np.end", 2, 1'b0, 16'h0, 4'h0, 1'b0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
